aes_req_scheduler: RTL and testbench
====================================

# aes_req_scheduler

Round-robin scheduler that shares one `AES_top` encryption core among `NUM_REQ` requesters. It accepts a (plaintext, key) job from one requester at a time and drives the core's enable, data and key inputs. It waits for the core's output-valid pulse, or a timeout, and returns the ciphertext tagged with the requester ID through a valid/ready response port. It sits between the system request fabric and `AES_top`, which is the only block that drives the core's inputs.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..4.
- `ID_W`, 2: width of the requester ID; `NUM_REQ <= 2**ID_W`.
- `TIMEOUT`, 64: maximum number of RUN cycles before the job is aborted; must be at least 8.
- `AES_clk` in 1: the single clock, rising edge.
- `AES_rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: per-requester job request.
- `req_ready` out NUM_REQ: one-hot acceptance pulse.
- `req_data` in NUM_REQ*128: plaintexts; requester i occupies bits [128i+127:128i].
- `req_key` in NUM_REQ*128: keys, packed the same way.
- `aes_en` out 1: core enable, to `AES_top.AES_en`.
- `aes_data_in` out 128: to `AES_top.AES_data_in`.
- `aes_key_in` out 128: to `AES_top.AES_key_in`.
- `aes_data_out` in 128: from `AES_top.AES_data_out`.
- `aes_data_out_valid` in 1: from `AES_top.AES_data_out_valid`.
- `resp_valid` out 1: response available.
- `resp_ready` in 1: response consumer ready.
- `resp_id` out ID_W: index of the requester that owns the response.
- `resp_data` out 128: ciphertext, or 0 on error.
- `resp_err` out 1: the job timed out.
- `busy` out 1: high when the state is not IDLE.

## Operation
- **States:** IDLE, RUN, RESP.
- **IDLE:**
  - If any `req_valid` bit is high, grant the first set bit searching upward from `last_grant+1` modulo NUM_REQ.
  - Pulse `req_ready[g]` for this one cycle. `req_ready` is a combinational function of state, `req_valid` and `last_grant`.
  - On the same edge: capture the granted data and key into `data_q`/`key_q`, set `id_q=g` and `last_grant=g`, clear `cnt`, and go to RUN.
- **RUN:**
  - `aes_en=1`.
  - `aes_data_in=data_q` and `aes_key_in=key_q`, held stable for the whole of RUN.
  - `cnt` increments every cycle.
  - If `aes_data_out_valid` is high and `cnt>=1`:
    - `resp_data<=aes_data_out`, `resp_err<=0`, `resp_id<=id_q`, go to RESP.
    - A valid seen while `cnt==0` is stale and is ignored.
  - Otherwise, if `cnt==TIMEOUT-1`: `resp_data<=0`, `resp_err<=1`, `resp_id<=id_q`, go to RESP.
  - A valid response takes priority over a timeout in the same cycle.
- **RESP:**
  - `aes_en=0`, `resp_valid=1`, and all response outputs are held stable.
  - When `resp_valid && resp_ready`, go to IDLE.
  - This guarantees `aes_en` is low for at least two consecutive cycles (RESP plus IDLE) between jobs.
- **Requester signals:** `req_valid` is ignored outside IDLE. A requester keeps `req_valid` high until its `req_ready` pulse arrives.
- **Reset:**
  - Reset is asynchronous and may arrive mid-operation. It returns the block to IDLE, abandons any job in flight, and produces no response.
  - The abandoned requester must re-request.

## Timing
- **Reset values:**
  - `req_ready=0`, `aes_en=0`, `aes_data_in=0`, `aes_key_in=0`.
  - `resp_valid=0`, `resp_id=0`, `resp_data=0`, `resp_err=0`, `busy=0`.
  - `last_grant=NUM_REQ-1`, so the first grant goes to requester 0.
  - `aes_data_in`/`aes_key_in` show `data_q`/`key_q` only in RUN and are 0 in every other state.
- **Acceptance:** `req_ready` is high in the cycle of acceptance, cycle T. `aes_en` rises at T+1.
- **Response latency:**
  - If the core asserts valid K cycles after `aes_en` rises (K>=1), `resp_valid` rises K+1 cycles after `aes_en` rises.
  - Back-to-back throughput is one job per (K+3) cycles when `resp_ready` is held high.
- **Timeout:** `resp_valid` rises TIMEOUT cycles after `aes_en` rises.
- **`cnt` width:** `cnt` is wide enough to count to TIMEOUT-1 (7 bits for the default) and never wraps.

## Test plan
- **Single job, reset release:** release reset; requester 0 sends data `00000058_00000000_00000000_00000000` with key `aa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc`. Core model returns valid after 20 cycles. Required: `resp_valid` with `resp_id=0`, `resp_err=0`, and `resp_data` equal to the core output, 21 cycles after `aes_en` rises.
- **Round-robin fairness:** all four `req_valid` held high with `resp_ready=1`. Required grant order is 0,1,2,3,0, with `aes_en` low for at least 2 cycles between jobs.
- **Response backpressure:** hold `resp_ready=0` for 10 cycles after `resp_valid` rises. Required: response outputs stable, `aes_en` stays 0, no new `req_ready`. Release `resp_ready`; the next grant occurs one cycle later.
- **Timeout:** core model never asserts valid. Required: `resp_err=1` and `resp_data=0` at 64 cycles after `aes_en` rises.
- **Stale valid:** `aes_data_out_valid` is high during the first RUN cycle and then low until cycle 15. Required: the response carries the core output from cycle 15.
- **Mid-run reset:** assert `AES_rst_n=0` in cycle 5 of RUN. Required: all outputs return to 0 immediately, and after release the next grant goes to requester 0.

Source files
------------

// File: rtl/aes_req_scheduler.sv
// Round-robin scheduler that shares one AES_top core among NUM_REQ requesters.
// It runs one job at a time, with a timeout, and returns an ID-tagged response over valid/ready.
module aes_req_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                   AES_clk,
  input  logic                   AES_rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*128-1:0] req_data,
  input  logic [NUM_REQ*128-1:0] req_key,
  output logic                   aes_en,
  output logic [127:0]           aes_data_in,
  output logic [127:0]           aes_key_in,
  input  logic [127:0]           aes_data_out,
  input  logic                   aes_data_out_valid,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_W-1:0]        resp_id,
  output logic [127:0]           resp_data,
  output logic                   resp_err,
  output logic                   busy
);

  localparam int              CNT_W      = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [ID_W-1:0]  last_grant_q, last_grant_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [127:0]     data_q, data_d;
  logic [127:0]     key_q, key_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]  resp_id_q, resp_id_d;
  logic [127:0]     resp_data_q, resp_data_d;
  logic             resp_err_q, resp_err_d;

  logic             grant_found;
  logic [ID_W-1:0]  grant_idx;
  int               cand;
  logic [127:0]     sel_data, sel_key;

  // The search starts one past the last winner, so each requester gets a turn.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = (int'(last_grant_q) + off) % NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grant_found && i == cand && req_valid[i]) begin
          grant_found = 1'b1;
          grant_idx   = ID_W'(i);
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    sel_data  = '0;
    sel_key   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_data     = req_data[i*128 +: 128];
        sel_key      = req_key[i*128 +: 128];
        req_ready[i] = (state_q == ST_IDLE) && grant_found;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    data_d       = data_q;
    key_d        = key_q;
    cnt_d        = cnt_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          state_d      = ST_RUN;
          last_grant_d = grant_idx;
          id_d         = grant_idx;
          data_d       = sel_data;
          key_d        = sel_key;
          cnt_d        = '0;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + 1'b1;
        // A valid in the first RUN cycle belongs to the previous job and is ignored.
        if (aes_data_out_valid && cnt_q != '0) begin
          state_d     = ST_RESP;
          resp_data_d = aes_data_out;
          resp_err_d  = 1'b0;
          resp_id_d   = id_q;
        end else if (cnt_q == TIMEOUT_M1) begin
          state_d     = ST_RESP;
          resp_data_d = '0;
          resp_err_d  = 1'b1;
          resp_id_d   = id_q;
        end
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      id_q         <= '0;
      data_q       <= '0;
      key_q        <= '0;
      cnt_q        <= '0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register update from pre-edge values.
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      data_q       <= data_d;
      key_q        <= key_d;
      cnt_q        <= cnt_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign aes_en      = (state_q == ST_RUN);
  assign aes_data_in = aes_en ? data_q : '0;
  assign aes_key_in  = aes_en ? key_q : '0;
  assign resp_valid  = (state_q == ST_RESP);
  assign resp_id     = resp_id_q;
  assign resp_data   = resp_data_q;
  assign resp_err    = resp_err_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_aes_req_scheduler.sv
// Scoreboard bench for aes_req_scheduler. It uses a simple core model and requester agents.
// A negedge monitor compares each response against queued expectations.
module tb_aes_req_scheduler;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 64;

  logic                   AES_clk = 1'b0;
  logic                   AES_rst_n;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*128-1:0] req_data;
  logic [NUM_REQ*128-1:0] req_key;
  logic                   aes_en;
  logic [127:0]           aes_data_in;
  logic [127:0]           aes_key_in;
  logic [127:0]           aes_data_out;
  logic                   aes_data_out_valid;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [ID_W-1:0]        resp_id;
  logic [127:0]           resp_data;
  logic                   resp_err;
  logic                   busy;

  aes_req_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
    .AES_clk            (AES_clk),
    .AES_rst_n          (AES_rst_n),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_data           (req_data),
    .req_key            (req_key),
    .aes_en             (aes_en),
    .aes_data_in        (aes_data_in),
    .aes_key_in         (aes_key_in),
    .aes_data_out       (aes_data_out),
    .aes_data_out_valid (aes_data_out_valid),
    .resp_valid         (resp_valid),
    .resp_ready         (resp_ready),
    .resp_id            (resp_id),
    .resp_data          (resp_data),
    .resp_err           (resp_err),
    .busy               (busy)
  );

  always #5 AES_clk = ~AES_clk;

  typedef struct {
    logic [ID_W-1:0] id;
    logic            err;
    logic [127:0]    data;
    int              lat;
  } exp_t;

  exp_t sb[$];
  exp_t exp_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   pending [NUM_REQ];
  logic [NUM_REQ-1:0] grant_seen;
  int   core_k;
  bit   stale;
  int   bp_cycles;
  bit   arm_next_grant, chk_grant;

  logic [127:0] data_tab [NUM_REQ] = '{
    128'h00000058_00000000_00000000_00000000,
    128'h11111111_22222222_33333333_44444444,
    128'hdeadbeef_01234567_89abcdef_fedcba98,
    128'h0badf00d_cafebabe_13572468_a5a5a5a5};
  logic [127:0] key_tab [NUM_REQ] = '{
    128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc,
    128'h0f0f0f0f_f0f0f0f0_00ff00ff_ff00ff00,
    128'h2b7e1516_28aed2a6_abf71588_09cf4f3c,
    128'h00010203_04050607_08090a0b_0c0d0e0f};

  // Stand-in for the core transform: any fixed function of data and key works here.
  function automatic logic [127:0] cipher(input logic [127:0] d, input logic [127:0] k);
    return {d[63:0], d[127:64]} ^ k ^ 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int id, input logic err, input logic [127:0] data, input int lat);
    exp_t e;
    e.id   = ID_W'(id);
    e.err  = err;
    e.data = data;
    e.lat  = lat;
    sb.push_back(e);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req_ready"}, 128'(req_ready), 128'd0);
    check({tag, "_en_valid_err_busy"}, 128'({aes_en, resp_valid, resp_err, busy}), 128'd0);
    check({tag, "_aes_data_in"}, aes_data_in, 128'd0);
    check({tag, "_aes_key_in"}, aes_key_in, 128'd0);
    check({tag, "_resp_data"}, resp_data, 128'd0);
    check({tag, "_resp_id"}, 128'(resp_id), 128'd0);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    @(negedge AES_clk);
    while ((sb.size() != 0 || busy || req_valid != '0) && n < budget) begin
      @(negedge AES_clk);
      n++;
    end
    check({name, "_done_in_budget"}, 128'(n < budget), 128'd1);
  endtask

  task automatic reset_pulse();
    @(negedge AES_clk);
    AES_rst_n = 1'b0;
    repeat (2) @(negedge AES_clk);
    #2 AES_rst_n = 1'b1;
  endtask

  always @(posedge AES_clk) cyc++;

  // Requester agents: keep req_valid up while jobs remain, drop one job per req_ready pulse.
  always @(posedge AES_clk) begin
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_seen[i] && pending[i] > 0) pending[i]--;
      req_valid[i] = (pending[i] > 0);
    end
    grant_seen = '0;
  end

  // Core model: valid core_k cycles after aes_en rises; optional stale valid in the first cycle.
  logic en_prev_c = 1'b0;
  int   en_cnt = 0;
  always @(posedge AES_clk) begin
    #1;
    if (aes_en && !en_prev_c) en_cnt = 0;
    else if (aes_en) en_cnt++;
    en_prev_c          = aes_en;
    aes_data_out_valid = 1'b0;
    aes_data_out       = 128'h5a5a5a5a_5a5a5a5a_5a5a5a5a_5a5a5a5a;
    if (aes_en) begin
      if (stale && en_cnt == 0) begin
        aes_data_out_valid = 1'b1;
        aes_data_out       = 128'hdead0000_dead0000_dead0000_dead0000;
      end else if (core_k > 0 && en_cnt == core_k) begin
        aes_data_out_valid = 1'b1;
        aes_data_out       = cipher(aes_data_in, aes_key_in);
      end
    end
  end

  always @(posedge AES_clk) begin
    #1;
    if (bp_cycles > 0 && resp_valid) begin
      resp_ready = 1'b0;
      bp_cycles--;
    end else begin
      resp_ready = 1'b1;
    end
  end

  logic            en_prev_m = 1'b0, rv_prev = 1'b0;
  int              en_rise = 0, rv_rise = 0, en_low = 0;
  bit              gap_armed = 1'b0;
  logic [ID_W-1:0] snap_id;
  logic [127:0]    snap_data;
  logic            snap_err;

  always @(negedge AES_clk) begin
    if (!AES_rst_n) begin
      en_prev_m = 1'b0;
      rv_prev   = 1'b0;
      en_low    = 0;
      gap_armed = 1'b0;
    end else begin
      if (chk_grant) begin
        check("grant_one_cycle_after_release", 128'(req_ready), 128'(4'b1000));
        chk_grant = 1'b0;
      end
      if (aes_en && !en_prev_m) begin
        en_rise = cyc;
        if (gap_armed) check("aes_en_low_gap_ge2", 128'(en_low >= 2), 128'd1);
        gap_armed = 1'b1;
      end
      en_low    = aes_en ? 0 : en_low + 1;
      en_prev_m = aes_en;
      if (resp_valid && !rv_prev) begin
        rv_rise   = cyc;
        snap_id   = resp_id;
        snap_data = resp_data;
        snap_err  = resp_err;
      end
      rv_prev = resp_valid;
      if (resp_valid && !resp_ready) begin
        check("bp_hold_id", 128'(resp_id), 128'(snap_id));
        check("bp_hold_data", resp_data, snap_data);
        check("bp_hold_err", 128'(resp_err), 128'(snap_err));
        check("bp_aes_en_low", 128'(aes_en), 128'd0);
        check("bp_no_req_ready", 128'(req_ready), 128'd0);
      end
      if (resp_valid && resp_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_resp: got id %0d with no job outstanding", resp_id);
        end else begin
          exp_e = sb.pop_front();
          check("resp_id", 128'(resp_id), 128'(exp_e.id));
          check("resp_err", 128'(resp_err), 128'(exp_e.err));
          check("resp_data", resp_data, exp_e.data);
          check("resp_latency", 128'(rv_rise - en_rise), 128'(exp_e.lat));
        end
        if (arm_next_grant) begin
          chk_grant      = 1'b1;
          arm_next_grant = 1'b0;
        end
      end
      grant_seen = grant_seen | req_ready;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    AES_rst_n          = 1'b0;
    req_valid          = '0;
    resp_ready         = 1'b1;
    aes_data_out_valid = 1'b0;
    aes_data_out       = '0;
    core_k             = 0;
    stale              = 1'b0;
    bp_cycles          = 0;
    arm_next_grant     = 1'b0;
    chk_grant          = 1'b0;
    grant_seen         = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pending[i]             = 0;
      req_data[i*128 +: 128] = data_tab[i];
      req_key[i*128 +: 128]  = key_tab[i];
    end
    repeat (3) @(negedge AES_clk);
    check_outputs_zero("reset");
    #2 AES_rst_n = 1'b1;

    // Single job after reset release: K=20, response 21 cycles after aes_en.
    @(negedge AES_clk);
    core_k = 20;
    push_exp(0, 1'b0, cipher(data_tab[0], key_tab[0]), 21);
    pending[0] = 1;
    wait_done("single", 200);

    // Round robin from a fresh reset: 0,1,2,3,0 with K=3.
    reset_pulse();
    @(negedge AES_clk);
    core_k = 3;
    push_exp(0, 1'b0, cipher(data_tab[0], key_tab[0]), 4);
    push_exp(1, 1'b0, cipher(data_tab[1], key_tab[1]), 4);
    push_exp(2, 1'b0, cipher(data_tab[2], key_tab[2]), 4);
    push_exp(3, 1'b0, cipher(data_tab[3], key_tab[3]), 4);
    push_exp(0, 1'b0, cipher(data_tab[0], key_tab[0]), 4);
    pending[0] = 2;
    pending[1] = 1;
    pending[2] = 1;
    pending[3] = 1;
    wait_done("round_robin", 300);

    // Backpressure: 10 cycles of resp_ready low; requester 3 waits the whole time.
    @(negedge AES_clk);
    bp_cycles      = 10;
    arm_next_grant = 1'b1;
    push_exp(2, 1'b0, cipher(data_tab[2], key_tab[2]), 4);
    push_exp(3, 1'b0, cipher(data_tab[3], key_tab[3]), 4);
    pending[2] = 1;
    pending[3] = 1;
    wait_done("backpressure", 300);

    // Timeout: core never answers.
    @(negedge AES_clk);
    core_k = 0;
    push_exp(1, 1'b1, 128'd0, TIMEOUT);
    pending[1] = 1;
    wait_done("timeout", 300);

    // Stale valid in the first RUN cycle, real valid at cycle 15.
    @(negedge AES_clk);
    core_k = 15;
    stale  = 1'b1;
    push_exp(2, 1'b0, cipher(data_tab[2], key_tab[2]), 16);
    pending[2] = 1;
    wait_done("stale", 200);
    stale = 1'b0;

    // Reset in cycle 5 of RUN for requester 0, then 0 must win again over 1.
    @(negedge AES_clk);
    core_k     = 0;
    pending[0] = 1;
    n = 0;
    while (!aes_en && n < 50) begin
      @(negedge AES_clk);
      n++;
    end
    check("midrun_job_started", 128'(aes_en), 128'd1);
    repeat (4) @(posedge AES_clk);
    #3 AES_rst_n = 1'b0;
    #1 check_outputs_zero("midrun_reset");
    repeat (2) @(negedge AES_clk);
    #2 AES_rst_n = 1'b1;
    @(negedge AES_clk);
    core_k = 2;
    push_exp(0, 1'b0, cipher(data_tab[0], key_tab[0]), 3);
    push_exp(1, 1'b0, cipher(data_tab[1], key_tab[1]), 3);
    pending[0] = 1;
    pending[1] = 1;
    wait_done("after_reset", 200);

    check("scoreboard_empty", 128'(sb.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
